// File: rtl/decode_stage_sequencer.sv
// decode_stage_sequencer
// Top-level scheduler for the image decompressor. Runs the SRAM-sharing stages
// UART loader -> M3 (lossless decode) -> M2 (IDCT) -> M1 (YUV->RGB) in fixed
// order. Each enabled stage gets a one-cycle start pulse. Ownership of the single
// SRAM port then passes to that stage until its done pulse. An idle gap is
// inserted between stages so that no write enable can carry over a handover.
//
// Parameters:
//   STAGE_MASK     - bit0 UART, bit1 M3, bit2 M2, bit3 M1; a 0 bit skips the stage
//   GAP_CYCLES     - idle cycles between stages (1..15)
//   TIMEOUT_CYCLES - per-stage watchdog limit (only with SEQ_WATCHDOG_EN)
// Ports:
//   Clock, Reset (synchronous, active-high), Start (one-cycle request)
//   Busy, Done (one-cycle pulse), Error (sticky watchdog error), Stage (state code)
//   <s>_start / <s>_done              - per-stage handshake, s in {uart, m3, m2, m1}
//   <s>_sram_address/_write_data/_we_n - per-stage SRAM request
//   SRAM_address/_write_data/_we_n     - muxed SRAM port
// Optional feature macro: SEQ_WATCHDOG_EN (adds the watchdog and the ERROR state).

module decode_stage_sequencer #(
  parameter logic [3:0]  STAGE_MASK     = 4'b1111,
  parameter int unsigned GAP_CYCLES     = 2,
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4_000_000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic        Start,
  output logic        Busy,
  output logic        Done,
  output logic        Error,
  output logic [2:0]  Stage,
  output logic        uart_start,
  output logic        m3_start,
  output logic        m2_start,
  output logic        m1_start,
  input  logic        uart_done,
  input  logic        m3_done,
  input  logic        m2_done,
  input  logic        m1_done,
  input  logic [17:0] uart_sram_address,
  input  logic [15:0] uart_sram_write_data,
  input  logic        uart_sram_we_n,
  input  logic [17:0] m3_sram_address,
  input  logic [15:0] m3_sram_write_data,
  input  logic        m3_sram_we_n,
  input  logic [17:0] m2_sram_address,
  input  logic [15:0] m2_sram_write_data,
  input  logic        m2_sram_we_n,
  input  logic [17:0] m1_sram_address,
  input  logic [15:0] m1_sram_write_data,
  input  logic        m1_sram_we_n,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n
);

  // Encoding equals the externally visible Stage code.
  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StUart  = 3'd1,
    StM3    = 3'd2,
    StM2    = 3'd3,
    StM1    = 3'd4,
    StGap   = 3'd5,
    StDone  = 3'd6,
    StError = 3'd7
  } state_e;

  // Owner codes share the stage state codes so a stage state converts directly.
  localparam logic [2:0] OwnNone = 3'd0;
  localparam logic [2:0] OwnUart = 3'd1;
  localparam logic [2:0] OwnM3   = 3'd2;
  localparam logic [2:0] OwnM2   = 3'd3;
  localparam logic [2:0] OwnM1   = 3'd4;

  state_e     state;
  state_e     gap_next;     // stage (or StDone) to enter when the gap expires
  state_e     first_stage;
  state_e     after_cur;
  logic [2:0] owner;
  logic       entry;        // high only in the first cycle of a stage
  logic [3:0] gap_cnt;
  logic       owner_done;

`ifdef SEQ_WATCHDOG_EN
  logic [23:0] wd_cnt;
`else
  logic [23:0] unused_timeout;
  assign unused_timeout = TIMEOUT_CYCLES;
`endif

  // First enabled stage whose code is above cur; StDone when none remain.
  function automatic state_e next_stage(input logic [2:0] cur);
    state_e nxt;
    logic   found;
    nxt   = StDone;
    found = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (!found && STAGE_MASK[i[1:0]] && (3'(i + 1) > cur)) begin
        nxt   = state_e'(3'(i + 1));
        found = 1'b1;
      end
    end
    return nxt;
  endfunction

  always_comb begin
    first_stage = next_stage(3'd0);
    after_cur   = next_stage(state);
  end

  // Only the owning stage's done is observed.
  always_comb begin
    owner_done = 1'b0;
    case (owner)
      OwnUart: owner_done = uart_done;
      OwnM3:   owner_done = m3_done;
      OwnM2:   owner_done = m2_done;
      OwnM1:   owner_done = m1_done;
      default: owner_done = 1'b0;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= StIdle;
      gap_next <= StDone;
      owner    <= OwnNone;
      entry    <= 1'b0;
      gap_cnt  <= 4'd0;
`ifdef SEQ_WATCHDOG_EN
      wd_cnt   <= 24'd0;
`endif
    end else begin
      entry <= 1'b0;
      case (state)
        StIdle: begin
          if (Start) begin
            if (first_stage == StDone) begin
              state <= StDone;
            end else begin
              state <= first_stage;
              owner <= first_stage;
              entry <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
              wd_cnt <= 24'd0;
`endif
            end
          end
        end
        StUart, StM3, StM2, StM1: begin
          // A done coinciding with the start pulse belongs to a previous run.
          if (!entry && owner_done) begin
            state    <= StGap;
            owner    <= OwnNone;
            gap_cnt  <= 4'(GAP_CYCLES - 1);
            gap_next <= after_cur;
          end
`ifdef SEQ_WATCHDOG_EN
          else if (wd_cnt == TIMEOUT_CYCLES - 24'd1) begin
            state <= StError;
            owner <= OwnNone;
          end else begin
            wd_cnt <= wd_cnt + 24'd1;
          end
`endif
        end
        StGap: begin
          if (gap_cnt == 4'd0) begin
            if (gap_next == StDone) begin
              state <= StDone;
            end else begin
              state <= gap_next;
              owner <= gap_next;
              entry <= 1'b1;
`ifdef SEQ_WATCHDOG_EN
              wd_cnt <= 24'd0;
`endif
            end
          end else begin
            gap_cnt <= gap_cnt - 4'd1;
          end
        end
        StDone:  state <= StIdle;
        StError: state <= StError;  // left only through Reset
        default: state <= StIdle;
      endcase
    end
  end

  assign Stage      = state;
  assign Busy       = (state != StIdle) && (state != StError);
  assign Done       = (state == StDone);
  assign uart_start = entry && (state == StUart);
  assign m3_start   = entry && (state == StM3);
  assign m2_start   = entry && (state == StM2);
  assign m1_start   = entry && (state == StM1);

`ifdef SEQ_WATCHDOG_EN
  assign Error = (state == StError);
`else
  assign Error = 1'b0;
`endif

  // Selected by the registered owner so the owning stage sees no added latency.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (owner)
      OwnUart: begin
        SRAM_address    = uart_sram_address;
        SRAM_write_data = uart_sram_write_data;
        SRAM_we_n       = uart_sram_we_n;
      end
      OwnM3: begin
        SRAM_address    = m3_sram_address;
        SRAM_write_data = m3_sram_write_data;
        SRAM_we_n       = m3_sram_we_n;
      end
      OwnM2: begin
        SRAM_address    = m2_sram_address;
        SRAM_write_data = m2_sram_write_data;
        SRAM_we_n       = m2_sram_we_n;
      end
      OwnM1: begin
        SRAM_address    = m1_sram_address;
        SRAM_write_data = m1_sram_write_data;
        SRAM_we_n       = m1_sram_we_n;
      end
      default: begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_decode_stage_sequencer.sv
// Directed bench for decode_stage_sequencer: a full-mask instance and a
// mask 4'b1010 instance sharing clock, reset and start.
module tb_decode_stage_sequencer;

  logic Clock;
  logic Reset;
  logic Start;

  // Full-mask instance
  logic        Busy, Done, Error;
  logic [2:0]  Stage;
  logic        uart_start, m3_start, m2_start, m1_start;
  logic [3:0]  a_done;
  logic [17:0] a_addr [4];
  logic [15:0] a_data [4];
  logic        a_we   [4];
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [3:0]  starts;

  // Skip-mask instance
  logic        k_busy, k_done_o, k_error;
  logic [2:0]  k_stage;
  logic        k_uart_start, k_m3_start, k_m2_start, k_m1_start;
  logic [3:0]  k_done;
  logic [17:0] k_addr;
  logic [15:0] k_data;
  logic        k_we_n;
  logic [3:0]  k_starts;

  int n_cmp = 0;
  int n_err = 0;

  assign starts   = {m1_start, m2_start, m3_start, uart_start};
  assign k_starts = {k_m1_start, k_m2_start, k_m3_start, k_uart_start};

  decode_stage_sequencer #(
    .STAGE_MASK    (4'b1111),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(24'd100)
  ) dut (
    .Clock               (Clock),
    .Reset               (Reset),
    .Start               (Start),
    .Busy                (Busy),
    .Done                (Done),
    .Error               (Error),
    .Stage               (Stage),
    .uart_start          (uart_start),
    .m3_start            (m3_start),
    .m2_start            (m2_start),
    .m1_start            (m1_start),
    .uart_done           (a_done[0]),
    .m3_done             (a_done[1]),
    .m2_done             (a_done[2]),
    .m1_done             (a_done[3]),
    .uart_sram_address   (a_addr[0]),
    .uart_sram_write_data(a_data[0]),
    .uart_sram_we_n      (a_we[0]),
    .m3_sram_address     (a_addr[1]),
    .m3_sram_write_data  (a_data[1]),
    .m3_sram_we_n        (a_we[1]),
    .m2_sram_address     (a_addr[2]),
    .m2_sram_write_data  (a_data[2]),
    .m2_sram_we_n        (a_we[2]),
    .m1_sram_address     (a_addr[3]),
    .m1_sram_write_data  (a_data[3]),
    .m1_sram_we_n        (a_we[3]),
    .SRAM_address        (SRAM_address),
    .SRAM_write_data     (SRAM_write_data),
    .SRAM_we_n           (SRAM_we_n)
  );

  decode_stage_sequencer #(
    .STAGE_MASK    (4'b1010),
    .GAP_CYCLES    (2),
    .TIMEOUT_CYCLES(24'd100)
  ) dut_skip (
    .Clock               (Clock),
    .Reset               (Reset),
    .Start               (Start),
    .Busy                (k_busy),
    .Done                (k_done_o),
    .Error               (k_error),
    .Stage               (k_stage),
    .uart_start          (k_uart_start),
    .m3_start            (k_m3_start),
    .m2_start            (k_m2_start),
    .m1_start            (k_m1_start),
    .uart_done           (k_done[0]),
    .m3_done             (k_done[1]),
    .m2_done             (k_done[2]),
    .m1_done             (k_done[3]),
    .uart_sram_address   (18'h00001),
    .uart_sram_write_data(16'h0001),
    .uart_sram_we_n      (1'b0),
    .m3_sram_address     (18'h00002),
    .m3_sram_write_data  (16'h0002),
    .m3_sram_we_n        (1'b0),
    .m2_sram_address     (18'h00003),
    .m2_sram_write_data  (16'h0003),
    .m2_sram_we_n        (1'b0),
    .m1_sram_address     (18'h00004),
    .m1_sram_write_data  (16'h0004),
    .m1_sram_we_n        (1'b0),
    .SRAM_address        (k_addr),
    .SRAM_write_data     (k_data),
    .SRAM_we_n           (k_we_n)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic tick;
    @(negedge Clock);
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at the negedge of a stage's entry cycle s; the stage reports done in
  // cycle s+10; returns at the negedge of cycle s+13.
  task automatic run_stage(input int idx);
    check($sformatf("start_pulse_%0d", idx), 32'(starts), 32'(1) << idx);
    check($sformatf("stage_code_%0d", idx), 32'(Stage), 32'(idx + 1));
    tick;
    check($sformatf("start_one_cycle_%0d", idx), 32'(starts), 32'd0);
    check($sformatf("mux_addr_%0d", idx), 32'(SRAM_address), 32'(a_addr[idx]));
    check($sformatf("mux_data_%0d", idx), 32'(SRAM_write_data), 32'(a_data[idx]));
    check($sformatf("mux_we_%0d", idx), 32'(SRAM_we_n), 32'(a_we[idx]));
    repeat (9) tick;
    a_done[idx] = 1'b1;
    tick;
    a_done[idx] = 1'b0;
    check($sformatf("gap_stage_%0d", idx), 32'(Stage), 32'd5);
    check($sformatf("gap_we_%0d", idx), 32'(SRAM_we_n), 32'd1);
    check($sformatf("gap_addr_%0d", idx), 32'(SRAM_address), 32'd0);
    check($sformatf("gap_data_%0d", idx), 32'(SRAM_write_data), 32'd0);
    tick;
    check($sformatf("gap2_stage_%0d", idx), 32'(Stage), 32'd5);
    check($sformatf("gap2_done_%0d", idx), 32'(Done), 32'd0);
    tick;
  endtask

  initial begin
    Reset  = 1'b1;
    Start  = 1'b0;
    a_done = 4'd0;
    k_done = 4'd0;
    a_addr[0] = 18'h01111; a_data[0] = 16'hA001; a_we[0] = 1'b0;
    a_addr[1] = 18'h02222; a_data[1] = 16'hA002; a_we[1] = 1'b1;
    a_addr[2] = 18'h03333; a_data[2] = 16'hA003; a_we[2] = 1'b0;
    a_addr[3] = 18'h3FFFF; a_data[3] = 16'hA004; a_we[3] = 1'b0;

    // Reset state
    tick;
    tick;
    check("rst_stage", 32'(Stage), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_done", 32'(Done), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    check("rst_starts", 32'(starts), 32'd0);
    check("rst_we", 32'(SRAM_we_n), 32'd1);
    check("rst_addr", 32'(SRAM_address), 32'd0);
    check("rst_data", 32'(SRAM_write_data), 32'd0);
    Reset = 1'b0;
    tick;

    // Full run: starts 13 cycles apart, Done 3 cycles after m1_done
    Start = 1'b1;
    tick;
    Start = 1'b0;
    check("full_busy", 32'(Busy), 32'd1);
    run_stage(0);
    run_stage(1);
    run_stage(2);
    run_stage(3);
    check("full_done", 32'(Done), 32'd1);
    check("full_done_stage", 32'(Stage), 32'd6);
    check("full_done_busy", 32'(Busy), 32'd1);
    Start = 1'b1;  // ignored in DONE
    tick;
    Start = 1'b0;
    check("done_pulse_end", 32'(Done), 32'd0);
    check("idle_after_done", 32'(Stage), 32'd0);
    check("idle_not_busy", 32'(Busy), 32'd0);
    tick;
    check("start_in_done_ignored", 32'(starts), 32'd0);
    check("still_idle", 32'(Stage), 32'd0);

    // Spurious events
    Start = 1'b1;
    tick;
    Start = 1'b0;
    check("sp_uart_start", 32'(starts), 32'd1);
    tick;
    tick;
    Start = 1'b1;  // while busy
    tick;
    Start = 1'b0;
    check("sp_restart_stage", 32'(Stage), 32'd1);
    check("sp_restart_starts", 32'(starts), 32'd0);
    repeat (7) tick;
    a_done[0] = 1'b1;
    tick;
    a_done[0] = 1'b0;
    tick;
    tick;
    check("sp_m3_start", 32'(starts), 32'd2);
    a_done[1] = 1'b1;  // entry-cycle done
    tick;
    check("sp_entry_done_ignored", 32'(Stage), 32'd2);
    tick;
    a_done[1] = 1'b0;
    check("sp_late_done_gap", 32'(Stage), 32'd5);
    tick;
    tick;
    check("sp_m2_start", 32'(starts), 32'd4);
    check("sp_m2_stage", 32'(Stage), 32'd3);

    // Reset during M2
    tick;
    tick;
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check("midrst_stage", 32'(Stage), 32'd0);
    check("midrst_we", 32'(SRAM_we_n), 32'd1);
    check("midrst_busy", 32'(Busy), 32'd0);
    check("midrst_addr", 32'(SRAM_address), 32'd0);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    check("midrst_restart", 32'(starts), 32'd1);
    check("midrst_restart_stage", 32'(Stage), 32'd1);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;

    // Skip mask 4'b1010: m3 then m1 only
    Start = 1'b1;
    tick;
    Start = 1'b0;
    check("skip_m3_start", 32'(k_starts), 32'd2);
    check("skip_m3_stage", 32'(k_stage), 32'd2);
    check("skip_mux_addr", 32'(k_addr), 32'd2);
    tick;
    tick;
    k_done = 4'b0101;  // uart_done and m2_done from non-owners
    tick;
    k_done = 4'd0;
    check("skip_foreign_done", 32'(k_stage), 32'd2);
    check("skip_foreign_busy", 32'(k_busy), 32'd1);
    tick;
    k_done[1] = 1'b1;
    tick;
    k_done[1] = 1'b0;
    check("skip_gap", 32'(k_stage), 32'd5);
    k_done[2] = 1'b1;
    tick;
    k_done[2] = 1'b0;
    check("skip_gap2", 32'(k_stage), 32'd5);
    tick;
    check("skip_m1_start", 32'(k_starts), 32'd8);
    check("skip_m1_stage", 32'(k_stage), 32'd4);
    check("skip_m1_mux", 32'(k_data), 32'd4);
    tick;
    tick;
    k_done[3] = 1'b1;
    tick;
    k_done[3] = 1'b0;
    tick;
    check("skip_pre_done", 32'(k_done_o), 32'd0);
    tick;
    check("skip_done", 32'(k_done_o), 32'd1);
    check("skip_done_stage", 32'(k_stage), 32'd6);
    tick;
    check("skip_idle", 32'(k_stage), 32'd0);

`ifdef SEQ_WATCHDOG_EN
    // Watchdog: m2 never finishes, timeout 100
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    a_done[0] = 1'b1;
    tick;
    a_done[0] = 1'b0;
    tick;
    tick;
    tick;
    a_done[1] = 1'b1;
    tick;
    a_done[1] = 1'b0;
    tick;
    tick;
    check("wd_m2_entry", 32'(Stage), 32'd3);
    repeat (99) tick;
    check("wd_before", 32'(Stage), 32'd3);
    check("wd_before_err", 32'(Error), 32'd0);
    tick;
    check("wd_stage", 32'(Stage), 32'd7);
    check("wd_error", 32'(Error), 32'd1);
    check("wd_busy", 32'(Busy), 32'd0);
    check("wd_we", 32'(SRAM_we_n), 32'd1);
    Start = 1'b1;
    tick;
    Start = 1'b0;
    tick;
    check("wd_start_ignored", 32'(Stage), 32'd7);
    check("wd_sticky", 32'(Error), 32'd1);
    Reset = 1'b1;
    tick;
    Reset = 1'b0;
    check("wd_reset_stage", 32'(Stage), 32'd0);
    check("wd_reset_error", 32'(Error), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
